// File: rtl/logic_accum_pkg.sv
// Shared op-code definitions for the logic accumulator unit.
package logic_accum_pkg;

   localparam int OP_W = 3;

   typedef logic [OP_W-1:0] op_t;

   localparam op_t OP_XOR    = 3'd0;
   localparam op_t OP_OR     = 3'd1;
   localparam op_t OP_XNOR   = 3'd2;
   localparam op_t OP_AND    = 3'd3;
   localparam op_t OP_NAND   = 3'd4;
   localparam op_t OP_NOR    = 3'd5;
   localparam op_t OP_LOAD   = 3'd6;
   localparam op_t OP_INVERT = 3'd7;

endpackage

// File: rtl/logic_accum_alu.sv
// Combinational bitwise operator: combines an operand with the current accumulator.
module logic_accum_alu
   import logic_accum_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] acc,
   input  logic [OP_W-1:0]  sel,
   output logic [WIDTH-1:0] result
);

   always_comb begin
      result = '0;
      case (sel)
         OP_XOR:    result = a ^ acc;
         OP_OR:     result = a | acc;
         OP_XNOR:   result = ~(a ^ acc);
         OP_AND:    result = a & acc;
         OP_NAND:   result = ~(a & acc);
         OP_NOR:    result = ~(a | acc);
         OP_LOAD:   result = a;
         OP_INVERT: result = ~acc;
         default:   result = '0;
      endcase
   end

endmodule

// File: rtl/logic_accum_unit.sv
// Two-stage valid/ready logic accumulator with saturating result counter.
// Optional registered Parity output when LOGIC_ACCUM_PARITY_EN is defined.
module logic_accum_unit
   import logic_accum_pkg::*;
#(
   parameter int               WIDTH    = 8,
   parameter logic [WIDTH-1:0] ACC_INIT = '0,
   parameter int               CNT_W    = 8
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic             In_valid,
   output logic             In_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [OP_W-1:0]  Sel,
   input  logic             Clear,
   output logic             Out_valid,
   input  logic             Out_ready,
   output logic [WIDTH-1:0] MuxOut,
   output logic [CNT_W-1:0] Count
`ifdef LOGIC_ACCUM_PARITY_EN
   ,
   output logic             Parity
`endif
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] s1_a_q, s1_a_d;
   logic [OP_W-1:0]  s1_sel_q, s1_sel_d;
   logic             s1_v_q, s1_v_d;
   logic             out_valid_q, out_valid_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [WIDTH-1:0] alu_result;
   logic             advance;
   logic             accept;

   logic_accum_alu #(
      .WIDTH (WIDTH)
   ) u_alu (
      .a      (s1_a_q),
      .acc    (acc_q),
      .sel    (s1_sel_q),
      .result (alu_result)
   );

   // Stage 1 may move forward whenever the output slot is empty or being drained.
   assign advance  = s1_v_q && (!out_valid_q || Out_ready);
   assign In_ready = Rst_n && !Clear && (!s1_v_q || !out_valid_q || Out_ready);
   assign accept   = In_valid && In_ready;

   always_comb begin
      acc_d       = acc_q;
      s1_a_d      = s1_a_q;
      s1_sel_d    = s1_sel_q;
      s1_v_d      = s1_v_q;
      out_valid_d = out_valid_q;
      count_d     = count_q;
      if (Clear) begin
         acc_d       = ACC_INIT;
         s1_v_d      = 1'b0;
         out_valid_d = 1'b0;
         count_d     = '0;
      end else begin
         if (advance) begin
            acc_d       = alu_result;
            out_valid_d = 1'b1;
            if (count_q != CNT_MAX) begin
               count_d = count_q + CNT_W'(1);
            end
         end else if (out_valid_q && Out_ready) begin
            out_valid_d = 1'b0;
         end
         if (accept) begin
            s1_a_d   = A;
            s1_sel_d = Sel;
            s1_v_d   = 1'b1;
         end else if (advance) begin
            s1_v_d = 1'b0;
         end
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         acc_q       <= ACC_INIT;
         s1_a_q      <= '0;
         s1_sel_q    <= '0;
         s1_v_q      <= 1'b0;
         out_valid_q <= 1'b0;
         count_q     <= '0;
      end else begin
         acc_q       <= acc_d;
         s1_a_q      <= s1_a_d;
         s1_sel_q    <= s1_sel_d;
         s1_v_q      <= s1_v_d;
         out_valid_q <= out_valid_d;
         count_q     <= count_d;
      end
   end

   assign Out_valid = out_valid_q;
   assign MuxOut    = acc_q;
   assign Count     = count_q;

`ifdef LOGIC_ACCUM_PARITY_EN
   logic parity_q, parity_d;

   // Tracks the accumulator's next value, so Clear and hold are covered for free.
   assign parity_d = ^acc_d;

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         parity_q <= ^ACC_INIT;
      end else begin
         parity_q <= parity_d;
      end
   end

   assign Parity = parity_q;
`endif

endmodule

// File: tb/tb_logic_accum_unit.sv
// Directed self-checking bench for logic_accum_unit; a second CNT_W=2 instance checks saturation.
module tb_logic_accum_unit;
   import logic_accum_pkg::*;

   logic       Clk;
   logic       Rst_n;
   logic       In_valid;
   logic [7:0] A;
   logic [2:0] Sel;
   logic       Clear;
   logic       Out_ready;

   logic       inReady, outValid;
   logic [7:0] muxOut;
   logic [7:0] count;
   logic       satInReady, satOutValid;
   logic [7:0] satMuxOut;
   logic [1:0] satCount;
`ifdef LOGIC_ACCUM_PARITY_EN
   logic       parity, satParity;
`endif

   int vectorCount = 0;
   int missCount   = 0;

   logic_accum_unit #(.WIDTH(8), .ACC_INIT(8'h00), .CNT_W(8)) dut (
      .Clk       (Clk),
      .Rst_n     (Rst_n),
      .In_valid  (In_valid),
      .In_ready  (inReady),
      .A         (A),
      .Sel       (Sel),
      .Clear     (Clear),
      .Out_valid (outValid),
      .Out_ready (Out_ready),
      .MuxOut    (muxOut),
      .Count     (count)
`ifdef LOGIC_ACCUM_PARITY_EN
      ,
      .Parity    (parity)
`endif
   );

   logic_accum_unit #(.WIDTH(8), .ACC_INIT(8'h00), .CNT_W(2)) dutSat (
      .Clk       (Clk),
      .Rst_n     (Rst_n),
      .In_valid  (In_valid),
      .In_ready  (satInReady),
      .A         (A),
      .Sel       (Sel),
      .Clear     (Clear),
      .Out_valid (satOutValid),
      .Out_ready (Out_ready),
      .MuxOut    (satMuxOut),
      .Count     (satCount)
`ifdef LOGIC_ACCUM_PARITY_EN
      ,
      .Parity    (satParity)
`endif
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectorCount++;
      if (observed !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic valid, input logic [7:0] a, input logic [2:0] sel, input logic clr);
      In_valid = valid;
      A        = a;
      Sel      = sel;
      Clear    = clr;
   endtask

   task automatic stepClock();
      @(posedge Clk);
      #1;
   endtask

   task automatic doClear();
      applyStimulus(1'b0, 8'h00, 3'd0, 1'b1);
      stepClock();
      applyStimulus(1'b0, 8'h00, 3'd0, 1'b0);
   endtask

   logic [7:0] seqA   [3] = '{8'hFF, 8'h0F, 8'h00};
   logic [2:0] seqSel [3] = '{OP_XOR, OP_AND, OP_INVERT};
   logic [7:0] seqExp [3] = '{8'hFF, 8'h0F, 8'hF0};

   initial begin
      Rst_n     = 1'b0;
      Out_ready = 1'b1;
      applyStimulus(1'b1, 8'h5A, OP_LOAD, 1'b0);
      #2;
      checkOutput("reset_in_ready", {31'd0, inReady}, 32'd0);
      checkOutput("reset_out_valid", {31'd0, outValid}, 32'd0);
      checkOutput("reset_mux_out", {24'd0, muxOut}, 32'h00);
      checkOutput("reset_count", {24'd0, count}, 32'd0);
`ifdef LOGIC_ACCUM_PARITY_EN
      checkOutput("reset_parity", {31'd0, parity}, 32'd0);
`endif
      stepClock();
      checkOutput("reset_hold_valid", {31'd0, outValid}, 32'd0);
      applyStimulus(1'b0, 8'h00, 3'd0, 1'b0);
      #2;
      Rst_n = 1'b1;
      stepClock();

      // Single OR operation: two-edge latency
      applyStimulus(1'b1, 8'h0F, OP_OR, 1'b0);
      stepClock();
      applyStimulus(1'b0, 8'h00, 3'd0, 1'b0);
      checkOutput("or_first_edge_valid", {31'd0, outValid}, 32'd0);
      stepClock();
      checkOutput("or_valid", {31'd0, outValid}, 32'd1);
      checkOutput("or_mux_out", {24'd0, muxOut}, 32'h0F);
      checkOutput("or_count", {24'd0, count}, 32'd1);
`ifdef LOGIC_ACCUM_PARITY_EN
      checkOutput("or_parity", {31'd0, parity}, 32'd0);
`endif
      stepClock();
      checkOutput("or_consumed", {31'd0, outValid}, 32'd0);

      // Clear then back-to-back XOR / AND / INVERT
      doClear();
      checkOutput("clear_mux_out", {24'd0, muxOut}, 32'h00);
      checkOutput("clear_count", {24'd0, count}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         if (i < 3) applyStimulus(1'b1, seqA[i], seqSel[i], 1'b0);
         else       applyStimulus(1'b0, 8'h00, 3'd0, 1'b0);
         stepClock();
         if (i >= 1) begin
            checkOutput($sformatf("b2b_valid_%0d", i), {31'd0, outValid}, 32'd1);
            checkOutput($sformatf("b2b_mux_%0d", i), {24'd0, muxOut}, {24'd0, seqExp[i-1]});
         end
      end
      checkOutput("b2b_count", {24'd0, count}, 32'd3);

      // Backpressure: two accepted, third refused, Sel change must not matter
      doClear();
      Out_ready = 1'b0;
      applyStimulus(1'b1, 8'h11, OP_LOAD, 1'b0);
      stepClock();
      applyStimulus(1'b1, 8'h22, OP_OR, 1'b0);
      checkOutput("bp_ready_second", {31'd0, inReady}, 32'd1);
      stepClock();
      applyStimulus(1'b1, 8'h44, OP_XOR, 1'b0);
      checkOutput("bp_ready_third", {31'd0, inReady}, 32'd0);
      stepClock();
      checkOutput("bp_mux_stall1", {24'd0, muxOut}, 32'h11);
      checkOutput("bp_valid_stall", {31'd0, outValid}, 32'd1);
      stepClock();
      checkOutput("bp_mux_stall2", {24'd0, muxOut}, 32'h11);
      applyStimulus(1'b0, 8'h00, OP_INVERT, 1'b0);
      Out_ready = 1'b1;
      #1;
      checkOutput("bp_ready_release", {31'd0, inReady}, 32'd1);
      stepClock();
      checkOutput("bp_drain_mux", {24'd0, muxOut}, 32'h33);
      checkOutput("bp_drain_valid", {31'd0, outValid}, 32'd1);
      checkOutput("bp_drain_count", {24'd0, count}, 32'd2);
      stepClock();
      checkOutput("bp_empty", {31'd0, outValid}, 32'd0);
      checkOutput("bp_final_count", {24'd0, count}, 32'd2);

      // Clear in the same cycle as an operand, accumulator at A5
      doClear();
      applyStimulus(1'b1, 8'hA5, OP_LOAD, 1'b0);
      stepClock();
      applyStimulus(1'b0, 8'h00, 3'd0, 1'b0);
      stepClock();
      checkOutput("clr_pre_mux", {24'd0, muxOut}, 32'hA5);
`ifdef LOGIC_ACCUM_PARITY_EN
      checkOutput("clr_pre_parity", {31'd0, parity}, 32'd0);
`endif
      applyStimulus(1'b1, 8'hFF, OP_LOAD, 1'b1);
      #1;
      checkOutput("clr_in_ready", {31'd0, inReady}, 32'd0);
      stepClock();
      applyStimulus(1'b0, 8'h00, 3'd0, 1'b0);
      checkOutput("clr_mux_out", {24'd0, muxOut}, 32'h00);
      checkOutput("clr_count", {24'd0, count}, 32'd0);
      checkOutput("clr_valid", {31'd0, outValid}, 32'd0);
      stepClock();
      stepClock();
      checkOutput("clr_dropped_valid", {31'd0, outValid}, 32'd0);
      checkOutput("clr_dropped_mux", {24'd0, muxOut}, 32'h00);

      // Saturation: five LOAD results on both instances
      for (int i = 0; i < 6; i++) begin
         if (i < 5) applyStimulus(1'b1, 8'(i + 1), OP_LOAD, 1'b0);
         else       applyStimulus(1'b0, 8'h00, 3'd0, 1'b0);
         stepClock();
         if (i >= 1) begin
            checkOutput($sformatf("sat_mux_%0d", i), {24'd0, muxOut}, i);
            checkOutput($sformatf("sat_count_%0d", i), {24'd0, count}, i);
            checkOutput($sformatf("sat_count2_%0d", i), {30'd0, satCount}, (i < 3) ? i : 3);
         end
      end

      // Reset pulse with an operand in flight
      doClear();
      applyStimulus(1'b1, 8'h77, OP_LOAD, 1'b0);
      stepClock();
      applyStimulus(1'b0, 8'h00, 3'd0, 1'b0);
      #1;
      Rst_n = 1'b0;
      #1;
      checkOutput("rst_mid_ready", {31'd0, inReady}, 32'd0);
      checkOutput("rst_mid_mux", {24'd0, muxOut}, 32'h00);
      #1;
      Rst_n = 1'b1;
      stepClock();
      checkOutput("rst_mid_no_valid", {31'd0, outValid}, 32'd0);
      stepClock();
      checkOutput("rst_mid_no_valid2", {31'd0, outValid}, 32'd0);
      applyStimulus(1'b1, 8'h3C, OP_LOAD, 1'b0);
      stepClock();
      applyStimulus(1'b0, 8'h00, 3'd0, 1'b0);
      stepClock();
      checkOutput("rst_after_valid", {31'd0, outValid}, 32'd1);
      checkOutput("rst_after_mux", {24'd0, muxOut}, 32'h3C);
      checkOutput("rst_after_count", {24'd0, count}, 32'd1);
`ifdef LOGIC_ACCUM_PARITY_EN
      checkOutput("rst_after_parity", {31'd0, parity}, 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule
